// File: rtl/serializer_param_if.sv
// rtl/serializer_param_if.sv - word-in / bit-out handshake bundle for serializer_param
//
// Purpose: carries the parallel word channel (word, bit count, valid/ready)
// and the serial output channel (bit, bit valid) between a producer and
// serializer_param.
//
// Signals:
//   data_i          DATA_W  parallel word
//   data_mod_i      MOD_W   bit count, 0 means DATA_W bits
//   data_val_i      1       word valid
//   data_rdy_o      1       serializer can accept a word
//   ser_data_o      1       serial bit
//   ser_data_val_o  1       ser_data_o carries a valid bit this cycle
//
// Modports:
//   slave   serializer side (consumes words, produces serial bits)
//   master  producer/sink side (drives words, observes serial bits)

interface serializer_param_if #(
  parameter int DATA_W = 16
);
  localparam int MOD_W = $clog2(DATA_W);

  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              data_rdy_o;
  logic              ser_data_o;
  logic              ser_data_val_o;

  modport slave (
    input  data_i,
    input  data_mod_i,
    input  data_val_i,
    output data_rdy_o,
    output ser_data_o,
    output ser_data_val_o
  );

  modport master (
    output data_i,
    output data_mod_i,
    output data_val_i,
    input  data_rdy_o,
    input  ser_data_o,
    input  ser_data_val_o
  );
endinterface

// File: rtl/serializer_param.sv
// rtl/serializer_param.sv - parametrised parallel-to-serial converter with one-word holding buffer
//
// Purpose: accepts a DATA_W-bit word plus a bit count over a valid/ready
// handshake and shifts that many bits out on a single wire, MSB- or
// LSB-first. A one-entry holding buffer lets the producer stream words
// back to back with no idle cycle between them. Words whose effective
// length is below MIN_LEN are consumed, dropped and flagged on err_o.
//
// Parameters:
//   DATA_W     parallel word width (>= 2)
//   MIN_LEN    shortest legal transfer length in bits (1 .. DATA_W)
//   MSB_FIRST  1: send data[DATA_W-1] downward, 0: send data[0] upward
//
// Ports:
//   clk_i    in   clock, all logic on the rising edge
//   arst_i   in   asynchronous active-high reset
//   bus      slave modport of serializer_param_if (word in, serial out)
//   busy_o   out  shifter active or holding buffer occupied
//   err_o    out  one-cycle pulse: an accepted word had an illegal length

module serializer_param #(
  parameter int DATA_W    = 16,
  parameter int MIN_LEN   = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              arst_i,
  serializer_param_if.slave bus,
  output logic              busy_o,
  output logic              err_o
);

  // Counter must hold DATA_W itself, hence one more bit than the mod field
  // for power-of-two widths.
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;        // bits still to send, incl. current
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [CNT_W-1:0]  buf_len_q, buf_len_d;
  logic              buf_full_q, buf_full_d;
  logic              err_q, err_d;

  logic              accept;
  logic              in_legal;
  logic [CNT_W-1:0]  in_len;
  logic              last_bit;
  logic              can_load;
  logic [DATA_W-1:0] shift_next;

  // Ready is held low during reset so nothing is handshaken while the
  // storage is being cleared.
  assign bus.data_rdy_o = !buf_full_q && !arst_i;
  assign accept         = bus.data_val_i && bus.data_rdy_o;

  assign in_len   = (bus.data_mod_i == '0) ? LEN_MAX : CNT_W'(bus.data_mod_i);
  assign in_legal = (in_len >= LEN_MIN) && (in_len <= LEN_MAX);

  // The shifter can take a new word when idle or while emitting its final
  // bit; that is what makes back-to-back words gapless.
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_ONE);
  assign can_load = (state_q == IDLE) || last_bit;

  // The outgoing bit is always at the same end of the register; the word is
  // loaded unaligned and shifted towards that end.
  assign shift_next = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    buf_data_d = buf_data_q;
    buf_len_d  = buf_len_q;
    buf_full_d = buf_full_q;
    err_d      = accept && !in_legal;

    if (state_q == SHIFT) begin
      shift_d = shift_next;
      cnt_d   = cnt_q - CNT_ONE;
      if (last_bit) begin
        state_d = IDLE;
      end
    end

    // The buffered word is older than anything on the input, so it wins.
    // While the buffer is full ready is low, so no input can be accepted
    // in the same cycle the buffer drains.
    if (can_load && buf_full_q) begin
      shift_d    = buf_data_q;
      cnt_d      = buf_len_q;
      state_d    = SHIFT;
      buf_full_d = 1'b0;
    end else if (can_load && accept && in_legal) begin
      shift_d = bus.data_i;
      cnt_d   = in_len;
      state_d = SHIFT;
    end else if (accept && in_legal) begin
      buf_data_d = bus.data_i;
      buf_len_d  = in_len;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      buf_data_q <= '0;
      buf_len_q  <= '0;
      buf_full_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      buf_data_q <= buf_data_d;
      buf_len_q  <= buf_len_d;
      buf_full_q <= buf_full_d;
      err_q      <= err_d;
    end
  end

  // Leftover register bits after the final shift are masked by the state.
  assign bus.ser_data_val_o = (state_q == SHIFT);
  assign bus.ser_data_o     = (state_q == SHIFT) &&
                              (MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0]);
  assign busy_o             = (state_q == SHIFT) || buf_full_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_serializer_param.sv
// tb/tb_serializer_param.sv - self-checking bench for serializer_param

module tb_serializer_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus, steered to one of three DUT builds by sel:
  //   0: DATA_W=16 MIN_LEN=3 MSB first
  //   1: DATA_W=16 MIN_LEN=3 LSB first
  //   2: DATA_W=8  MIN_LEN=1 MSB first
  int          sel;
  logic [15:0] drv_data;
  logic [3:0]  drv_mod;
  logic        drv_val;

  serializer_param_if #(.DATA_W(16)) ia ();
  serializer_param_if #(.DATA_W(16)) ib ();
  serializer_param_if #(.DATA_W(8))  ic ();

  assign ia.data_i     = drv_data;
  assign ia.data_mod_i = drv_mod;
  assign ia.data_val_i = drv_val && (sel == 0);
  assign ib.data_i     = drv_data;
  assign ib.data_mod_i = drv_mod;
  assign ib.data_val_i = drv_val && (sel == 1);
  assign ic.data_i     = drv_data[7:0];
  assign ic.data_mod_i = drv_mod[2:0];
  assign ic.data_val_i = drv_val && (sel == 2);

  logic busy_a, err_a, busy_b, err_b, busy_c, err_c;

  serializer_param #(.DATA_W(16), .MIN_LEN(3), .MSB_FIRST(1'b1)) dut_a (
    .clk_i(clk), .arst_i(rst), .bus(ia), .busy_o(busy_a), .err_o(err_a));
  serializer_param #(.DATA_W(16), .MIN_LEN(3), .MSB_FIRST(1'b0)) dut_b (
    .clk_i(clk), .arst_i(rst), .bus(ib), .busy_o(busy_b), .err_o(err_b));
  serializer_param #(.DATA_W(8), .MIN_LEN(1), .MSB_FIRST(1'b1)) dut_c (
    .clk_i(clk), .arst_i(rst), .bus(ic), .busy_o(busy_c), .err_o(err_c));

  logic cur_rdy, cur_sd, cur_sv, cur_busy, cur_err;
  always_comb begin
    cur_rdy = ia.data_rdy_o; cur_sd = ia.ser_data_o; cur_sv = ia.ser_data_val_o;
    cur_busy = busy_a; cur_err = err_a;
    case (sel)
      1: begin
        cur_rdy = ib.data_rdy_o; cur_sd = ib.ser_data_o; cur_sv = ib.ser_data_val_o;
        cur_busy = busy_b; cur_err = err_b;
      end
      2: begin
        cur_rdy = ic.data_rdy_o; cur_sd = ic.ser_data_o; cur_sv = ic.ser_data_val_o;
        cur_busy = busy_c; cur_err = err_c;
      end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s sel=%0d t=%0t got %b expected %b", name, sel, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s sel=%0d t=%0t got %0d expected %0d", name, sel, $time, act, exp);
    end
  endtask

  // Reference model: expected serial bit stream, one entry per bit.
  logic exp_q[$];

  task automatic push_word(input int s, input logic [15:0] d, input logic [3:0] m,
                           output bit illegal);
    int dw, minl, len, mval;
    bit msb;
    dw   = (s == 2) ? 8 : 16;
    minl = (s == 2) ? 1 : 3;
    msb  = (s != 1);
    mval = (s == 2) ? int'(m[2:0]) : int'(m);
    len  = (mval == 0) ? dw : mval;
    illegal = (len < minl) || (len > dw);
    if (!illegal) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back(msb ? d[dw-1-i] : d[i]);
      end
    end
  endtask

  typedef struct {
    int          s;
    logic [15:0] data;
    logic [3:0]  mod;
    int          exp_len;
    logic [15:0] exp_seq;   // first serial bit at exp_seq[exp_len-1]
    logic        exp_err;
  } vec_t;

  task automatic apply_vec(input vec_t v);
    sel = v.s; drv_data = v.data; drv_mod = v.mod; drv_val = 1'b1;
    #1;
    check("rdy_before", cur_rdy, 1'b1);
    @(negedge clk);
    drv_val = 1'b0;
    if (v.exp_err) begin
      check("err_pulse", cur_err, 1'b1);
      check("err_no_val", cur_sv, 1'b0);
      check("err_rdy", cur_rdy, 1'b1);
      @(negedge clk);
      check("err_clear", cur_err, 1'b0);
      check("err_no_val2", cur_sv, 1'b0);
    end else begin
      for (int i = 0; i < v.exp_len; i++) begin
        check("ser_val", cur_sv, 1'b1);
        check("ser_bit", cur_sd, v.exp_seq[v.exp_len-1-i]);
        check("ser_busy", cur_busy, 1'b1);
        @(negedge clk);
      end
      check("ser_end_val", cur_sv, 1'b0);
      check("ser_end_zero", cur_sd, 1'b0);
      check("ser_end_busy", cur_busy, 1'b0);
    end
  endtask

  task automatic run_b2b();
    logic [15:0] words [3];
    int  idx;
    bit  acc, started, ended, gap, rdy_low, dummy;
    logic got[$];
    words[0] = 16'hC3A5; words[1] = 16'h0FF0; words[2] = 16'h9669;
    idx = 0; acc = 0; started = 0; ended = 0; gap = 0; rdy_low = 0;
    sel = 0; exp_q.delete();
    for (int i = 0; i < 3; i++) push_word(0, words[i], 4'd0, dummy);
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (acc) idx++;
      if (cur_sv) begin
        if (ended) gap = 1;
        got.push_back(cur_sd);
        started = 1;
      end else if (started) begin
        ended = 1;
      end
      if (!cur_rdy && idx < 3) rdy_low = 1;
      drv_val  = (idx < 3);
      drv_data = words[(idx < 3) ? idx : 0];
      drv_mod  = 4'd0;
      acc = drv_val && cur_rdy;
    end
    drv_val = 1'b0;
    check_int("b2b_accepted", idx, 3);
    check_int("b2b_bits", got.size(), 48);
    check("b2b_no_gap", gap, 1'b0);
    check("b2b_rdy_dropped", rdy_low, 1'b1);
    for (int i = 0; i < 48 && i < got.size(); i++) check("b2b_bit", got[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic run_random(input int s, input int cycles);
    bit acc, exp_err;
    logic [15:0] acc_d;
    logic [3:0]  acc_m;
    sel = s; exp_q.delete(); drv_val = 1'b0; acc = 0; acc_d = '0; acc_m = '0;
    for (int cyc = 0; cyc < cycles + 40; cyc++) begin
      @(negedge clk);
      exp_err = 0;
      if (acc) push_word(s, acc_d, acc_m, exp_err);
      check("rnd_err", cur_err, exp_err);
      check("rnd_busy", cur_busy, exp_q.size() > 0);
      check("rnd_val", cur_sv, exp_q.size() > 0);
      if (cur_sv && exp_q.size() > 0) check("rnd_bit", cur_sd, exp_q.pop_front());
      else if (!cur_sv) check("rnd_zero", cur_sd, 1'b0);
      if (cyc < cycles) begin
        drv_val  = ($urandom_range(0, 3) != 0);
        drv_data = 16'($urandom);
        drv_mod  = 4'($urandom_range(0, 15));
      end else begin
        drv_val = 1'b0;
      end
      acc = drv_val && cur_rdy; acc_d = drv_data; acc_m = drv_mod;
    end
    check_int("rnd_drained", exp_q.size(), 0);
    drv_val = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{0, 16'hA5F0, 4'd0,  16, 16'hA5F0, 1'b0};
    vecs[1] = '{0, 16'hB000, 4'd3,   3, 16'h0005, 1'b0};
    vecs[2] = '{0, 16'hB000, 4'd1,   0, 16'h0000, 1'b1};
    vecs[3] = '{0, 16'hB000, 4'd2,   0, 16'h0000, 1'b1};
    vecs[4] = '{0, 16'hFFFF, 4'd5,   5, 16'h001F, 1'b0};
    vecs[5] = '{0, 16'h8001, 4'd15, 15, 16'h4000, 1'b0};
    vecs[6] = '{1, 16'h0006, 4'd4,   4, 16'h0006, 1'b0};
    vecs[7] = '{1, 16'hA5F0, 4'd0,  16, 16'h0FA5, 1'b0};
    vecs[8] = '{2, 16'h00A5, 4'd0,   8, 16'h00A5, 1'b0};
    vecs[9] = '{2, 16'h0080, 4'd1,   1, 16'h0001, 1'b0};

    rst = 1'b1; sel = 0; drv_val = 1'b0; drv_data = '0; drv_mod = '0;

    // Reset state, during and just after reset, for every build.
    @(negedge clk); @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("rst_rdy", cur_rdy, 1'b0);
      check("rst_val", cur_sv, 1'b0);
      check("rst_bit", cur_sd, 1'b0);
      check("rst_busy", cur_busy, 1'b0);
      check("rst_err", cur_err, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("post_rst_rdy", cur_rdy, 1'b1);
      check("post_rst_val", cur_sv, 1'b0);
      check("post_rst_busy", cur_busy, 1'b0);
    end
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i]);
      @(negedge clk);
    end

    run_b2b();
    @(negedge clk);

    // Reset in the middle of a 16-bit word, then a clean word afterwards.
    sel = 0; drv_data = 16'hFFFF; drv_mod = 4'd0; drv_val = 1'b1;
    @(negedge clk);
    drv_val = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    check("mid_val", cur_sv, 1'b1);
    check("mid_bit", cur_sd, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_val", cur_sv, 1'b0);
    check("arst_bit", cur_sd, 1'b0);
    check("arst_busy", cur_busy, 1'b0);
    check("arst_rdy", cur_rdy, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_rdy", cur_rdy, 1'b1);
    check("rel_val", cur_sv, 1'b0);
    check("rel_busy", cur_busy, 1'b0);
    apply_vec('{0, 16'h8001, 4'd0, 16, 16'h8001, 1'b0});
    @(negedge clk);

    run_random(2, 600);
    run_random(0, 600);
    run_random(1, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serializer_param.md
# serializer_param

Parametrised parallel-to-serial converter, successor to the fixed 16-bit serializer in the lab1 block. Accepts a DATA_W-bit word plus a bit-count over a valid/ready handshake and shifts out that many bits, MSB- or LSB-first. A one-word holding buffer allows gapless back-to-back streaming. It sits between a word-oriented producer and a single-wire serial sink, in the same clock domain.

## Interface
- DATA_W, 16, parallel word width; must be ≥ 2.
- MIN_LEN, 3, shortest legal transfer length in bits; must satisfy 1 ≤ MIN_LEN ≤ DATA_W.
- MSB_FIRST, 1, 1 sends the word from data_i[DATA_W-1] downward; 0 sends it from data_i[0] upward.
- MOD_W, $clog2(DATA_W), width of data_mod_i (derived, not overridden).

- clk_i  in  1  single clock; all logic on rising edge.
- arst_i  in  1  reset, asynchronous and active-high.
- data_i  in  DATA_W  parallel word.
- data_mod_i  in  MOD_W  bit count; 0 means DATA_W bits.
- data_val_i  in  1  word valid.
- data_rdy_o  out  1  block can accept a word; a transfer occurs when data_val_i && data_rdy_o.
- ser_data_o  out  1  serial bit.
- ser_data_val_o  out  1  ser_data_o is a valid bit this cycle.
- busy_o  out  1  shifter active or buffer occupied.
- err_o  out  1  one-cycle pulse: an accepted word had an illegal length and was dropped.

## Operation
- Effective length: len = (data_mod_i == 0) ? DATA_W : data_mod_i.
  - Legal when MIN_LEN ≤ len ≤ DATA_W.
  - An illegal word is still consumed by the handshake, is discarded and pulses err_o. It never enters the shifter or the buffer.
- Storage:
  - Shift register: DATA_W bits, with a bit counter.
  - Holding buffer: one entry (word + len) with a full flag.
- Shifter states: IDLE and SHIFT.
  - IDLE → SHIFT when a legal word is loaded.
  - SHIFT → SHIFT on the last bit if a word is available to load (buffer full, or a legal word accepted that cycle while the buffer is empty).
  - SHIFT → IDLE on the last bit otherwise.
- Load priority at the last bit or in IDLE:
  - Buffer contents load first.
  - Otherwise an incoming legal word loads directly into the shifter.
- A word accepted while the shifter is busy and not finishing goes into the buffer.
- data_rdy_o = !buffer_full, forced to 0 while arst_i is high.
- Bit order:
  - MSB_FIRST=1: data[DATA_W-1] down to data[DATA_W-len].
  - MSB_FIRST=0: data[0] up to data[len-1].
- Bits outside the selected range are ignored.
- ser_data_o is 0 whenever ser_data_val_o = 0.
- busy_o = (state == SHIFT) || buffer_full.
- data_i and data_mod_i are sampled only on the handshake cycle; later changes have no effect.

## Timing
- Reset values (asynchronous, while arst_i high, and on the first edge after release):
  - ser_data_o = 0, ser_data_val_o = 0, busy_o = 0, err_o = 0.
  - Buffer empty, state IDLE.
  - data_rdy_o = 0 during reset, 1 after release.
- Latency: a word accepted at edge k (shifter idle) gives ser_data_val_o = 1 for exactly cycles k+1 … k+len; busy_o follows the same window.
- Back-to-back: the next word's first bit appears in the cycle immediately after the previous word's last bit, with no idle cycle, whenever that word is buffered or presented on the last-bit cycle.
- data_rdy_o falls the cycle after a word enters the buffer. It rises the cycle after the buffer drains into the shifter.
- err_o is high in cycle k+1 for an illegal word accepted at edge k, with no effect on an ongoing transfer.
- Reset mid-transfer: output stops immediately (asynchronous). The shifter and buffer contents are lost, and no partial word resumes.
- Simultaneous last bit + buffer full + data_val_i: data_rdy_o = 0, so the new word is not accepted. The buffer loads into the shifter, and the input is accepted the following cycle.

## Test plan
- DATA_W=16, MSB_FIRST=1: send 0xA5F0 with mod=0 → 16 valid cycles, bits 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0, starting the cycle after the handshake.
- Send 0xB000 with mod=3 → exactly 3 valid cycles, bits 1,0,1. Then mod=1 and mod=2 → err_o pulse each, no ser_data_val_o, data_rdy_o stays 1.
- MSB_FIRST=0, send 0x0006 with mod=4 → bits 0,1,1,0.
- Hold data_val_i high with three 16-bit words → 48 contiguous valid cycles with no gap. data_rdy_o drops while the buffer is full, and all words arrive in order.
- Assert arst_i at bit 7 of a 16-bit transfer → all outputs 0 immediately. After release, data_rdy_o = 1, and a new word 0x8001 serialises correctly from its first bit.
- DATA_W=8, MIN_LEN=1 build: mod=0 → 8 bits; mod=1 → 1 bit; random words and lengths are checked against a reference-model scoreboard.
